// File: rtl/nibble_word_packer.sv
// nibble_word_packer: packs NIBBLES 4-bit DO nibbles MSB-first into a word offered on a valid/ready port
// Ports:
//   clka, RESTART_N          clock, asynchronous active-low reset
//   DO, DO_VLD               incoming nibble and its qualifier
//   FLUSH                    emit the partial word, zero-padded in its low slots
//   CLR_OVF                  clear sticky OVF (a drop on the same edge wins)
//   WORD, WORD_CNT, WORD_PAR output word, real-nibble count, XOR of WORD bits
//   WORD_VLD, WORD_RDY       output handshake
//   OVF                      sticky: a nibble was dropped while a word was held
module nibble_word_packer #(
  parameter int NIBBLES = 4,
  parameter int CW = $clog2(NIBBLES + 1)
) (
  input  logic                 clka,
  input  logic                 RESTART_N,
  input  logic [3:0]           DO,
  input  logic                 DO_VLD,
  input  logic                 FLUSH,
  input  logic                 CLR_OVF,
  output logic [4*NIBBLES-1:0] WORD,
  output logic [CW-1:0]        WORD_CNT,
  output logic                 WORD_PAR,
  output logic                 WORD_VLD,
  input  logic                 WORD_RDY,
  output logic                 OVF
);
  localparam int W = 4 * NIBBLES;
  typedef enum logic [1:0] {A_EMPTY, A_FILL, A_FULL} state_t;
  state_t state_q, state_d;
  logic [W-1:0] asm_q, asm_d, asm_n, word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n, wcnt_q, wcnt_d;
  logic vld_q, vld_d, par_q, par_d, ovf_q, ovf_d;
  logic full, cap, done, free, drain, load;
  always_comb begin
    full = state_q == A_FULL;
    drain = vld_q & WORD_RDY;
    free = !vld_q | WORD_RDY;
    cap = DO_VLD & !full;
    asm_n = asm_q;
    for (int i = 0; i < NIBBLES; i++)
      if (cap && cnt_q == CW'(i)) asm_n[W-1-4*i -: 4] = DO;
    cnt_n = cnt_q + CW'(cap);
    // a nibble on the FLUSH edge is included first; FLUSH with nothing captured is a no-op
    done = !full & ((cnt_n == CW'(NIBBLES)) | (FLUSH & (cnt_n != '0)));
    // output loads either a just-completed word or the word held in A_FULL
    load = (done & free) | (full & drain);
    word_d = load ? (full ? asm_q : asm_n) : word_q;
    wcnt_d = load ? (full ? cnt_q : cnt_n) : wcnt_q;
    par_d = load ? ^word_d : par_q;
    vld_d = load | (vld_q & !WORD_RDY);
    state_d = load ? A_EMPTY : (full | done) ? A_FULL : (cnt_n == '0) ? A_EMPTY : A_FILL;
    asm_d = load ? '0 : asm_n;
    cnt_d = load ? '0 : cnt_n;
    ovf_d = (DO_VLD & full) | (ovf_q & !CLR_OVF);
  end
  always_ff @(posedge clka or negedge RESTART_N) begin
    if (!RESTART_N) begin
      state_q <= A_EMPTY;
      asm_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      wcnt_q <= '0;
      par_q <= 1'b0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q <= asm_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      wcnt_q <= wcnt_d;
      par_q <= par_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end
  assign WORD = word_q;
  assign WORD_CNT = wcnt_q;
  assign WORD_PAR = par_q;
  assign WORD_VLD = vld_q;
  assign OVF = ovf_q;
endmodule

// File: tb/tb_nibble_word_packer.sv
// tb_nibble_word_packer: scoreboard bench for nibble_word_packer with NIBBLES=4
module tb_nibble_word_packer;
  logic clka = 0, RESTART_N = 0, DO_VLD = 0, FLUSH = 0, CLR_OVF = 0, WORD_RDY = 0;
  logic [3:0] DO = 0;
  logic [15:0] WORD;
  logic [2:0] WORD_CNT;
  logic WORD_PAR, WORD_VLD, OVF;
  typedef struct packed {logic [15:0] w; logic [2:0] c; logic p;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  nibble_word_packer #(.NIBBLES(4), .CW(3)) dut (
    .clka(clka), .RESTART_N(RESTART_N), .DO(DO), .DO_VLD(DO_VLD), .FLUSH(FLUSH),
    .CLR_OVF(CLR_OVF), .WORD(WORD), .WORD_CNT(WORD_CNT), .WORD_PAR(WORD_PAR),
    .WORD_VLD(WORD_VLD), .WORD_RDY(WORD_RDY), .OVF(OVF)
  );
  always #5 clka = ~clka;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clka);
    #1;
  endtask
  task automatic send(input logic [3:0] d);
    DO = d;
    DO_VLD = 1;
    cyc();
    DO_VLD = 0;
  endtask
  task automatic push(input logic [15:0] w, input logic [2:0] c);
    q.push_back({w, c, ^w});
  endtask
  always @(negedge clka)
    if (RESTART_N && WORD_VLD && WORD_RDY) begin
      chk("q_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("word", 32'(WORD), 32'(e.w));
        chk("cnt", 32'(WORD_CNT), 32'(e.c));
        chk("par", 32'(WORD_PAR), 32'(e.p));
      end
    end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    #1;
    chk("rst_word", 32'(WORD), 32'd0);
    chk("rst_cnt", 32'(WORD_CNT), 32'd0);
    chk("rst_par", 32'(WORD_PAR), 32'd0);
    chk("rst_vld", 32'(WORD_VLD), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    #11 RESTART_N = 1;
    cyc();
    WORD_RDY = 1;
    push(16'h1234, 4);
    for (int i = 1; i <= 4; i++) send(4'(i));
    chk("t1_vld", 32'(WORD_VLD), 32'd1);
    cyc();
    chk("t1_vld_drop", 32'(WORD_VLD), 32'd0);
    WORD_RDY = 0;
    push(16'h1234, 4);
    push(16'h5678, 4);
    for (int i = 1; i <= 9; i++) send(4'(i));
    chk("t2_ovf", 32'(OVF), 32'd1);
    chk("t2_hold", 32'(WORD), 32'h1234);
    chk("t2_vld", 32'(WORD_VLD), 32'd1);
    CLR_OVF = 1;
    send(4'hA);
    CLR_OVF = 0;
    chk("t6_set_wins", 32'(OVF), 32'd1);
    CLR_OVF = 1;
    cyc();
    CLR_OVF = 0;
    chk("t6_clr", 32'(OVF), 32'd0);
    chk("t2_still_hold", 32'(WORD), 32'h1234);
    WORD_RDY = 1;
    cyc();
    chk("t2_b2b_vld", 32'(WORD_VLD), 32'd1);
    chk("t2_b2b_word", 32'(WORD), 32'h5678);
    cyc();
    chk("t2_vld_drop", 32'(WORD_VLD), 32'd0);
    push(16'hAB00, 2);
    send(4'hA);
    send(4'hB);
    FLUSH = 1;
    cyc();
    FLUSH = 0;
    chk("t3_vld", 32'(WORD_VLD), 32'd1);
    chk("t3_cnt", 32'(WORD_CNT), 32'd2);
    cyc();
    FLUSH = 1;
    cyc();
    FLUSH = 0;
    chk("t3_empty_flush", 32'(WORD_VLD), 32'd0);
    push(16'hCDE0, 3);
    send(4'hC);
    send(4'hD);
    FLUSH = 1;
    send(4'hE);
    FLUSH = 0;
    chk("t4_cnt", 32'(WORD_CNT), 32'd3);
    cyc();
    push(16'h7000, 1);
    FLUSH = 1;
    send(4'h7);
    FLUSH = 0;
    chk("one_nib_cnt", 32'(WORD_CNT), 32'd1);
    push(16'h1234, 4);
    for (int i = 1; i <= 3; i++) send(4'(i));
    FLUSH = 1;
    send(4'h4);
    FLUSH = 0;
    chk("flush_full_cnt", 32'(WORD_CNT), 32'd4);
    cyc();
    WORD_RDY = 0;
    for (int i = 1; i <= 9; i++) send(4'(i));
    chk("t5_pre_vld", 32'(WORD_VLD), 32'd1);
    chk("t5_pre_ovf", 32'(OVF), 32'd1);
    #3 RESTART_N = 0;
    #1;
    chk("t5_rst_vld", 32'(WORD_VLD), 32'd0);
    chk("t5_rst_ovf", 32'(OVF), 32'd0);
    chk("t5_rst_word", 32'(WORD), 32'd0);
    #2 WORD_RDY = 1;
    RESTART_N = 1;
    cyc();
    send(4'h1);
    send(4'h2);
    #3 RESTART_N = 0;
    #1;
    chk("t5_rst2_vld", 32'(WORD_VLD), 32'd0);
    #3 RESTART_N = 1;
    cyc();
    push(16'h5678, 4);
    for (int i = 5; i <= 8; i++) send(4'(i));
    chk("t5_word", 32'(WORD), 32'h5678);
    chk("t5_cnt", 32'(WORD_CNT), 32'd4);
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    cyc();
    chk("q_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
